lane_unstripe_4to1: RTL

//   Merges four registered 9-bit lanes ({valid,data[7:0]}, lane 0 first) back into one

---
 rtl/lane_unstripe_4to1.sv | 94 +++++++++
 1 files changed

// File: rtl/lane_unstripe_4to1.sv
// lane_unstripe_4to1: merges four 9-bit lanes ({valid,data}) back into one byte stream.
// Each accepted word is buffered whole. Its per-lane valid bits act as a pending mask.
// Bytes are drained one per cycle in lane order, and invalid lanes are skipped.
//
// Handshake: the input word transfers on a posedge where in_ready=1 and at least one lane
// is valid. The output byte transfers on a posedge where out[8]=1 and out_ready=1. While
// out[8]=1 and out_ready=0, out holds steady. When out[8]=0, out is 9'h000.
module lane_unstripe_4to1 #(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       in0,
    input  logic [8:0]       in1,
    input  logic [8:0]       in2,
    input  logic [8:0]       in3,
    output logic             in_ready,
    output logic [8:0]       out,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [7:0]       data_q [DEPTH][4];
    logic [3:0]       pend_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic [7:0]       lane_data [4];
    logic [3:0]       lane_vld;
    logic             push;
    logic [3:0]       head_pend;
    logic [1:0]       sel;
    logic [3:0]       sel_bit;
    logic [3:0]       rest;
    logic             out_vld;
    logic             take;
    logic             pop;

    // Input unpacking, flow control and head-lane selection.
    always_comb begin
        lane_data[0] = in0[7:0];
        lane_data[1] = in1[7:0];
        lane_data[2] = in2[7:0];
        lane_data[3] = in3[7:0];
        lane_vld     = {in3[8], in2[8], in1[8], in0[8]};

        // No pass-through when full: in_ready only looks at registered count.
        in_ready = reset & (count != DEPTH_C);
        push     = in_ready & (|lane_vld);

        head_pend = pend_q[rd_ptr];
        sel       = 2'd0;
        if (head_pend[0])      sel = 2'd0;
        else if (head_pend[1]) sel = 2'd1;
        else if (head_pend[2]) sel = 2'd2;
        else if (head_pend[3]) sel = 2'd3;
        sel_bit = 4'b0001 << sel;
        rest    = head_pend & ~sel_bit;

        // A held word always has at least one pending lane, so count!=0 means a byte is ready.
        out_vld = (count != '0);
        out     = out_vld ? {1'b1, data_q[rd_ptr][sel]} : 9'h000;
        take    = out_vld & out_ready;
        pop     = take & (rest == 4'd0);
    end

    // Word storage, pending masks, pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                pend_q[w] <= 4'd0;
                for (int l = 0; l < 4; l++) data_q[w][l] <= 8'h00;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Push and head-clear never hit the same slot: that would need count==0 (no take)
            // or count==DEPTH (no push).
            if (take) pend_q[rd_ptr] <= rest;
            if (push) begin
                for (int l = 0; l < 4; l++) data_q[wr_ptr][l] <= lane_data[l];
                pend_q[wr_ptr] <= lane_vld;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

endmodule
